// File: rtl/vga_pixel_sink_pkg.sv
// Shared pixel-stream types for the VGA pixel sink: field widths and the packed
// {x, y, colour} record that travels through the buffer.
package vga_pixel_sink_pkg;

    localparam int VGA_X_W   = 8;
    localparam int VGA_Y_W   = 7;
    localparam int VGA_COL_W = 3;
    localparam int PIXEL_W   = VGA_X_W + VGA_Y_W + VGA_COL_W;

    typedef struct packed {
        logic [VGA_X_W-1:0]   x;
        logic [VGA_Y_W-1:0]   y;
        logic [VGA_COL_W-1:0] colour;
    } pixel_t;

    function automatic pixel_t pack_pixel(input logic [VGA_X_W-1:0]   x,
                                          input logic [VGA_Y_W-1:0]   y,
                                          input logic [VGA_COL_W-1:0] colour);
        pixel_t p;
        p.x      = x;
        p.y      = y;
        p.colour = colour;
        return p;
    endfunction

endpackage

// File: rtl/vga_pixel_sink_pixel_fifo.sv
// Synchronous pixel FIFO: registered write at wr_ptr, read data presented from rd_ptr.
// Caller guarantees push only when not full and pop only when not empty.
import vga_pixel_sink_pkg::*;

module pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  pixel_t            wr_data,
    output pixel_t            rd_data,
    output logic [ADDR_W:0]   count
);

    pixel_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/vga_pixel_sink.sv
// Buffers producer pixel writes and replays them to the VGA adapter, one pixel
// every drain_div+1 cycles, without ever dropping an accepted write.
import vga_pixel_sink_pkg::*;

module vga_pixel_sink #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DIV_W  = 21
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [DIV_W-1:0]     drain_div,
    input  logic [VGA_X_W-1:0]   in_x,
    input  logic [VGA_Y_W-1:0]   in_y,
    input  logic [VGA_COL_W-1:0] in_colour,
    input  logic                 in_write,
    output logic                 in_ready,
    output logic [VGA_X_W-1:0]   vga_x,
    output logic [VGA_Y_W-1:0]   vga_y,
    output logic [VGA_COL_W-1:0] vga_colour,
    output logic                 vga_write,
    output logic [ADDR_W:0]      count,
    output logic                 idle,
    output logic                 overflow
);

    logic             clear;
    logic             push_p0;
    logic             pop_p0;
    logic [DIV_W-1:0] pc;
    pixel_t           pix_p0;
    pixel_t           pix_p1;
    logic             vld_p1;

    assign clear    = reset | flush;
    assign in_ready = (count != (ADDR_W+1)'(DEPTH));
    assign push_p0  = in_write & in_ready & ~clear;
    assign pop_p0   = (pc == '0) & (count != '0) & ~clear;

    pixel_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock   (clock),
        .clear   (clear),
        .push    (push_p0),
        .pop     (pop_p0),
        .wr_data (pack_pixel(in_x, in_y, in_colour)),
        .rd_data (pix_p0),
        .count   (count)
    );

    // drain_div is only sampled on reload, so changing it mid-interval has no effect.
    always_ff @(posedge clock) begin
        if (clear) begin
            pc <= '0;
        end else if (pc != '0) begin
            pc <= pc - DIV_W'(1);
        end else if (count != '0) begin
            pc <= drain_div;
        end
    end

    // ---- stage p0 -> p1: output register toward the adapter ----
    always_ff @(posedge clock) begin
        if (clear) begin
            vld_p1 <= 1'b0;
            pix_p1 <= '0;
        end else begin
            vld_p1 <= pop_p0;
            pix_p1 <= pop_p0 ? pix_p0 : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            overflow <= 1'b0;
        end else if (in_write && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    assign vga_x      = pix_p1.x;
    assign vga_y      = pix_p1.y;
    assign vga_colour = pix_p1.colour;
    assign vga_write  = vld_p1;
    assign idle       = (count == '0) & ~vld_p1;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Self-checking bench for vga_pixel_sink: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_vga_pixel_sink;

    logic        clk = 0;
    logic        reset, flush;
    logic [20:0] drain_div;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_write;
    logic        in_ready;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_write;
    logic [4:0]  count;
    logic        idle;
    logic        overflow;

    vga_pixel_sink #(.DEPTH(16), .ADDR_W(4), .DIV_W(21)) dut (
        .clock(clk), .reset(reset), .flush(flush), .drain_div(drain_div),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_write(in_write),
        .in_ready(in_ready), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_write(vga_write), .count(count), .idle(idle), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: a queue of pending pixels plus a countdown to the next emission.
    logic [17:0] m_q[$];
    int          m_wait;
    logic        m_vw;
    logic [17:0] m_pix;
    logic        m_ovf;

    typedef struct { int cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c; } out_t;
    out_t out_log[$];

    typedef struct {
        logic       wr;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       exp_vw;
        logic [7:0] exp_x;
        logic [6:0] exp_y;
        logic [2:0] exp_c;
        logic [4:0] exp_cnt;
        logic       exp_idle;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic ready;
        ready = (m_q.size() != 16);
        if (reset || flush) begin
            m_q.delete();
            m_wait = 0; m_vw = 0; m_pix = '0; m_ovf = 0;
        end else begin
            if (m_wait == 0 && m_q.size() != 0) begin
                m_vw   = 1;
                m_pix  = m_q.pop_front();
                m_wait = int'(drain_div);
            end else begin
                m_vw  = 0;
                m_pix = '0;
                if (m_wait != 0) m_wait--;
            end
            if (in_write) begin
                if (ready) m_q.push_back({in_x, in_y, in_colour});
                else       m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("vga_write", vga_write, m_vw);
        chk("vga_pixel", {vga_x, vga_y, vga_colour}, m_pix);
        chk("count", count, m_q.size());
        chk("in_ready", in_ready, m_q.size() != 16);
        chk("idle", idle, (m_q.size() == 0) && !m_vw);
        chk("overflow", overflow, m_ovf);
        if (vga_write) out_log.push_back('{cyc, vga_x, vga_y, vga_colour});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic drive(input logic wr, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        in_write = wr; in_x = x; in_y = y; in_colour = c;
    endtask

    initial begin
        reset = 1; flush = 0; drain_div = '0;
        drive(0, 0, 0, 0);
        m_q.delete(); m_wait = 0; m_vw = 0; m_pix = '0; m_ovf = 0;
        @(negedge clk);
        tick(); tick();
        reset = 0;

        // Reset then idle
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_vga_write", vga_write, 0);
            chk("idle_count", count, 0);
            chk("idle_in_ready", in_ready, 1);
            chk("idle_idle", idle, 1);
            chk("idle_overflow", overflow, 0);
        end

        // Single pixel latency, drain_div=0
        tbl[0] = '{1'b1, 8'd10, 7'd20, 3'd5, 1'b0, 8'd0,  7'd0,  3'd0, 5'd1, 1'b0};
        tbl[1] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 8'd10, 7'd20, 3'd5, 5'd0, 1'b0};
        tbl[2] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 8'd0,  7'd0,  3'd0, 5'd0, 1'b1};
        tbl[3] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 8'd0,  7'd0,  3'd0, 5'd0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i].wr, tbl[i].x, tbl[i].y, tbl[i].c);
            tick();
            chk("tbl_vga_write", vga_write, tbl[i].exp_vw);
            chk("tbl_vga_x", vga_x, tbl[i].exp_x);
            chk("tbl_vga_y", vga_y, tbl[i].exp_y);
            chk("tbl_vga_colour", vga_colour, tbl[i].exp_c);
            chk("tbl_count", count, tbl[i].exp_cnt);
            chk("tbl_idle", idle, tbl[i].exp_idle);
        end

        // drain_div=3: five pulses spaced four cycles apart
        drain_div = 21'd3;
        out_log.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(i + 1), 7'(2 * i), 3'(i));
            tick();
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 30; i++) tick();
        chk("div3_n_out", out_log.size(), 5);
        for (int j = 0; j < out_log.size() && j < 5; j++) begin
            chk("div3_order_x", out_log[j].x, j + 1);
            chk("div3_order_y", out_log[j].y, 2 * j);
            if (j > 0) chk("div3_spacing", out_log[j].cyc - out_log[j-1].cyc, 4);
        end

        // Pointer wrap: 40 pixels streamed at full rate
        drain_div = '0;
        out_log.delete();
        for (int i = 0; i < 40; i++) begin
            drive(1, 8'(i * 3), 7'(i), 3'(i));
            tick();
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("wrap_n_out", out_log.size(), 40);
        for (int j = 0; j < out_log.size() && j < 40; j++) begin
            chk("wrap_order", {out_log[j].x, out_log[j].y, out_log[j].c},
                {8'(j * 3), 7'(j), 3'(j)});
        end

        // Fill to full and overrun once with a slow drain
        drain_div = 21'd100;
        out_log.delete();
        for (int i = 0; i < 18; i++) begin
            drive(1, 8'(100 + i), 7'(i), 3'(i));
            tick();
            if (i == 16) begin
                chk("full_in_ready", in_ready, 0);
                chk("full_count", count, 16);
                chk("full_overflow", overflow, 0);
            end
        end
        drive(0, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        for (int i = 0; i < 1900 && out_log.size() < 17; i++) tick();
        chk("ovf_n_out", out_log.size(), 17);
        for (int j = 0; j < out_log.size() && j < 17; j++) begin
            chk("ovf_order", out_log[j].x, 100 + j);
        end
        chk("ovf_sticky", overflow, 1);

        // Flush mid-drain
        drain_div = 21'd5;
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(200 + i), 7'(i), 3'(7 - i));
            tick();
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("flush_count", count, 0);
        chk("flush_vga_write", vga_write, 0);
        chk("flush_overflow", overflow, 0);
        out_log.delete();
        for (int i = 0; i < 30; i++) tick();
        chk("flush_no_writes", out_log.size(), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) drain_div = 21'($urandom_range(0, 4));
            flush = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 6, 8'($urandom), 7'($urandom), 3'($urandom));
            tick();
        end
        flush = 0;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
